camera_qsys_key_in: RTL

Avalon-MM slave input PIO for the board push-buttons and switches. It is the read-side counterpart of the existing LED output PIO and uses the same s1 register-style interface. Raw pins pass through a 2-flop synchronizer and a per-bit debouncer, then edge detection. Edges latch into a write-1-to-clear edge-capture register, and a masked level interrupt goes to the HPS/Nios IRQ line.

---
 rtl/camera_qsys_pio_pkg.sv | 17 +
 rtl/camera_qsys_key_debounce.sv | 52 +++++
 rtl/camera_qsys_key_in.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/camera_qsys_pio_pkg.sv
// Shared definitions for the camera_qsys PIO blocks.
// Holds the register word offsets of the s1 slave and the encodings for
// the edge-detect selection.
package camera_qsys_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_MASK    = 2'd1;
   localparam logic [1:0] ADDR_RSVD    = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   typedef enum int {
      EDGE_RISE = 0,
      EDGE_FALL = 1,
      EDGE_ANY  = 2
   } edge_type_e;

endpackage

// File: rtl/camera_qsys_key_debounce.sv
// One-bit debouncer for a key or switch input.
// A new level is accepted once the already-synchronized input has
// differed from the current level on STABLE_TICKS consecutive ticks.
// With BYPASS set, the output follows the input combinationally.
// Ports:
//   clk     system clock
//   reset_n asynchronous active-low reset
//   tick    one-cycle sample strobe
//   din     synchronized input bit
//   dout    debounced level
module camera_qsys_key_debounce #(
   parameter int STABLE_TICKS = 4,
   parameter bit BYPASS       = 1'b0,
   parameter bit RESET_LEVEL  = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic din,
   output logic dout
);

   localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

   logic [3:0] cnt;
   logic       level;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         level <= RESET_LEVEL;
      end else if (BYPASS) begin
         cnt   <= '0;
         level <= din;
      end else if (tick) begin
         if (din != level) begin
            // The tick that brings the count to STABLE_TICKS also commits.
            if (cnt == CNT_LAST) begin
               level <= din;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign dout = BYPASS ? din : level;

endmodule

// File: rtl/camera_qsys_key_in.sv
// Avalon-MM input PIO for board push-buttons and switches.
// Pins are synchronized, debounced per bit, edge-detected, and the
// selected edges latch into a write-1-to-clear capture register. A masked,
// registered level interrupt is raised while any unmasked capture bit is set.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word address (0 data, 1 irq mask, 2 reserved, 3 edge capture)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data, latency 1
//   in_port    raw asynchronous pins
//   irq        active-high level interrupt
module camera_qsys_key_in
   import camera_qsys_pio_pkg::*;
#(
   parameter int               WIDTH        = 4,
   parameter int               TICK_DIV     = 50000,
   parameter int               STABLE_TICKS = 4,
   parameter int               EDGE_TYPE    = 0,
   parameter logic [WIDTH-1:0] RESET_LEVEL  = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [WIDTH-1:0] sync_1;
   logic [WIDTH-1:0] sync_2;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] wdata_w;
   logic [WIDTH-1:0] clr;
   logic             wr_en;
   logic             rd_en;
   logic [31:0]      rd_mux;

   // Sample tick generator; held idle when debouncing is bypassed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (TICK_DIV == 0 || tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick = (TICK_DIV != 0) && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= RESET_LEVEL;
         sync_2 <= RESET_LEVEL;
      end else begin
         sync_1 <= in_port;
         sync_2 <= sync_1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      camera_qsys_key_debounce #(
         .STABLE_TICKS (STABLE_TICKS),
         .BYPASS       (TICK_DIV == 0),
         .RESET_LEVEL  (RESET_LEVEL[i])
      ) u_deb (
         .clk     (clk),
         .reset_n (reset_n),
         .tick    (tick),
         .din     (sync_2[i]),
         .dout    (level[i])
      );
   end

   // prev resets to the same value as level, so reset release never
   // looks like an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= RESET_LEVEL;
      end else begin
         prev <= level;
      end
   end

   always_comb begin
      edge_det = level & ~prev;
      if (EDGE_TYPE == int'(EDGE_FALL)) begin
         edge_det = ~level & prev;
      end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
         edge_det = level ^ prev;
      end
   end

   assign wr_en   = chipselect & ~write_n;
   assign rd_en   = chipselect & write_n;
   assign wdata_w = writedata[WIDTH-1:0];
   assign clr     = (wr_en && address == ADDR_EDGECAP) ? wdata_w : '0;

   if (WIDTH < 32) begin : g_unused_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
   end

   // A new edge in the same cycle as a clearing write keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture <= '0;
         irq_mask     <= '0;
         irq          <= 1'b0;
      end else begin
         edge_capture <= (edge_capture & ~clr) | edge_det;
         if (wr_en && address == ADDR_MASK) begin
            irq_mask <= wdata_w;
         end
         irq <= |(edge_capture & irq_mask);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux[WIDTH-1:0] = level;
         ADDR_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (rd_en) begin
         readdata <= rd_mux;
      end
   end

endmodule
